div_restore_core: RTL



---
 rtl/div_restore_core.sv | 107 ++++++++++
 1 files changed

// File: rtl/div_restore_core.sv
`default_nettype none
// ============================================================================
// Module      : div_restore_core
// Description : Sequential unsigned restoring divider. One quotient bit is
//               resolved per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_restore_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   c_CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // The MSB of the (WIDTH+1)-bit partial remainder and of M is always 0
    // between iterations, so only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;

    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_sel;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_load;
    logic             w_iter;

    // Shift, trial subtract, and the restore mux.
    assign w_a_shift = {r_a, r_q[WIDTH-1]};
    assign w_diff    = w_a_shift - {1'b0, r_m};
    assign w_sel     = ~w_diff[WIDTH];
    assign w_a_next  = w_sel ? w_diff[WIDTH-1:0] : w_a_shift[WIDTH-1:0];
    assign w_q_next  = {r_q[WIDTH-2:0], w_sel};

    assign w_load = (r_state == S_IDLE) && start;
    assign w_iter = (r_state == S_RUN);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN:  if (r_cnt == c_CNT_LAST) w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_load) begin
            r_a   <= '0;
            r_q   <= dividend;
            r_m   <= divisor;
            r_cnt <= c_CNT_INIT;
            r_dbz <= (divisor == '0);
        end else if (w_iter) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - c_CNT_LAST;
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_q;
    assign remainder   = r_a;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
